// File: rtl/wb_unit.sv
// Writeback stage and register scoreboard: arbitrates EXU/LSU results onto the
// register-file write port and tracks which registers have a write in flight.
module wb_unit #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    input  logic [4:0]        iss_rd,
    output logic              iss_ready,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    output logic              rs1_busy,
    output logic              rs2_busy,
    input  logic              exu_valid,
    input  logic [4:0]        exu_rd,
    input  logic [DATA_W-1:0] exu_data,
    output logic              exu_ready,
    input  logic              lsu_valid,
    input  logic [4:0]        lsu_rd,
    input  logic [DATA_W-1:0] lsu_data,
    output logic              lsu_ready,
    output logic              rf_wen,
    output logic [4:0]        rf_rd,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              err
);

    localparam int         IDX_W  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [5:0] NREG_L = 6'(NREG);

    function automatic logic in_range(input logic [4:0] r);
        return {1'b0, r} < NREG_L;
    endfunction

    logic [NREG-1:0]   busy_q, busy_d;
    logic [NREG-1:0]   set_mask, clr_mask;
    logic              rf_wen_q, rf_wen_d;
    logic [4:0]        rf_rd_q, rf_rd_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
    logic              err_q, err_d;
    logic              last_lsu_q, last_lsu_d;

    logic              iss_in, iss_fire;
    logic              conflict, sel_lsu, res_fire;
    logic [4:0]        res_rd;
    logic [DATA_W-1:0] res_data;
    logic              res_in, res_busy, res_write;

    always_comb begin
        iss_in    = in_range(iss_rd);
        iss_ready = iss_in ? !busy_q[iss_rd[IDX_W-1:0]] : 1'b1;
        iss_fire  = iss_valid && iss_ready;

        rs1_busy  = in_range(rs1) && busy_q[rs1[IDX_W-1:0]];
        rs2_busy  = in_range(rs2) && busy_q[rs2[IDX_W-1:0]];

        // On a conflict the source that lost the previous conflict wins.
        conflict  = exu_valid && lsu_valid;
        sel_lsu   = lsu_valid && (!exu_valid || !last_lsu_q);
        exu_ready = !sel_lsu && (exu_valid || !lsu_valid);
        lsu_ready = sel_lsu || (!exu_valid && !lsu_valid);
        res_fire  = (exu_valid && exu_ready) || (lsu_valid && lsu_ready);
        res_rd    = sel_lsu ? lsu_rd : exu_rd;
        res_data  = sel_lsu ? lsu_data : exu_data;

        res_in    = in_range(res_rd);
        res_busy  = res_in && busy_q[res_rd[IDX_W-1:0]];
        res_write = res_fire && res_in && (res_rd != 5'd0);
    end

    // Per-register set/clear strobes; x0 never becomes busy.
    assign set_mask[0] = 1'b0;
    assign clr_mask[0] = 1'b0;
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
        assign set_mask[gi] = iss_fire && (iss_rd == 5'(gi));
        assign clr_mask[gi] = rf_wen_q && (rf_rd_q == 5'(gi));
    end

    always_comb begin
        // Set is applied after clear so it wins on a same-index collision.
        busy_d     = (busy_q & ~clr_mask) | set_mask;
        last_lsu_d = conflict ? sel_lsu : last_lsu_q;
        rf_wen_d   = res_write;
        rf_rd_d    = res_write ? res_rd : rf_rd_q;
        rf_wdata_d = res_write ? res_data : rf_wdata_q;
        err_d      = err_q
                   | (iss_fire && !iss_in)
                   | (res_fire && !res_in)
                   | (res_write && !res_busy);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= '0;
            rf_wen_q   <= 1'b0;
            rf_rd_q    <= 5'd0;
            rf_wdata_q <= '0;
            err_q      <= 1'b0;
            last_lsu_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rf_wen_q   <= rf_wen_d;
            rf_rd_q    <= rf_rd_d;
            rf_wdata_q <= rf_wdata_d;
            err_q      <= err_d;
            last_lsu_q <= last_lsu_d;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_rd    = rf_rd_q;
    assign rf_wdata = rf_wdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Scoreboard bench for wb_unit: expected writes are queued as results are driven
// and matched against the register-file port as writes appear.
module tb_wb_unit;
    localparam int DATA_W = 32;
    localparam int NREG   = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              iss_valid, iss_ready;
    logic [4:0]        iss_rd, rs1, rs2;
    logic              rs1_busy, rs2_busy;
    logic              exu_valid, exu_ready;
    logic [4:0]        exu_rd;
    logic [DATA_W-1:0] exu_data;
    logic              lsu_valid, lsu_ready;
    logic [4:0]        lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              rf_wen, err;
    logic [4:0]        rf_rd;
    logic [DATA_W-1:0] rf_wdata;

    wb_unit #(.DATA_W(DATA_W), .NREG(NREG)) dut (
        .clk(clk), .rst(rst),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
        .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks = 0;
    int  n_pass   = 0;
    bit  exp_last_lsu;
    bit  grant_lsu;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [DATA_W-1:0] d);
        wr_t w;
        w.rd   = rd;
        w.data = d;
        exp_q.push_back(w);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1 && rf_wen === 1'b1) begin
            $display("write x%0d = 0x%08h", rf_rd, rf_wdata);
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", rf_wen, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("sb_rd", rf_rd, mon_e.rd);
                check_eq("sb_data", rf_wdata, mon_e.data);
            end
        end
    end

    initial begin
        rst = 1'b0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
        exu_valid = 0; exu_rd = 0; exu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        exp_last_lsu = 1'b0;
        tick(); tick();
        check_eq("rst_rf_wen", rf_wen, 0);
        check_eq("rst_rf_rd", rf_rd, 0);
        check_eq("rst_rf_wdata", rf_wdata, 0);
        check_eq("rst_err", err, 0);
        rst = 1'b1;
        tick();

        // Issue x5, then EXU result for x5.
        rs1 = 5; iss_valid = 1; iss_rd = 5; settle();
        check_eq("a_iss_ready", iss_ready, 1);
        tick();
        iss_valid = 0; exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF; settle();
        check_eq("a_rs1_busy_issued", rs1_busy, 1);
        check_eq("a_exu_ready", exu_ready, 1);
        push(5, 32'hDEADBEEF);
        tick();
        exu_valid = 0; settle();
        check_eq("a_rf_wen", rf_wen, 1);
        check_eq("a_rf_rd", rf_rd, 5);
        check_eq("a_rs1_busy_wb", rs1_busy, 1);
        tick();
        check_eq("a_rs1_busy_clear", rs1_busy, 0);
        check_eq("a_rf_wen_off", rf_wen, 0);
        check_eq("a_rf_rd_hold", rf_rd, 5);
        check_eq("a_rf_wdata_hold", rf_wdata, 32'hDEADBEEF);
        check_eq("a_err", err, 0);

        // WAW stall on x3.
        rs1 = 3; iss_valid = 1; iss_rd = 3; settle();
        check_eq("b_iss_ready_first", iss_ready, 1);
        tick();
        check_eq("b_iss_ready_stall", iss_ready, 0);
        check_eq("b_rs1_busy", rs1_busy, 1);
        tick();
        check_eq("b_iss_ready_stall2", iss_ready, 0);
        exu_valid = 1; exu_rd = 3; exu_data = 32'h33333333;
        push(3, 32'h33333333);
        tick();
        exu_valid = 0; settle();
        check_eq("b_iss_ready_wb", iss_ready, 0);
        tick();
        check_eq("b_iss_ready_free", iss_ready, 1);
        tick();
        iss_valid = 0; exu_valid = 1; exu_rd = 3; exu_data = 32'h33330001;
        push(3, 32'h33330001);
        tick();
        exu_valid = 0;
        tick();
        check_eq("b_rs1_busy_clear", rs1_busy, 0);
        check_eq("b_err", err, 0);

        // x0 issue and result: accepted, no write, no error.
        rs1 = 0; rs2 = 7; iss_valid = 1; iss_rd = 0;
        lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h0000ABCD; settle();
        check_eq("e_iss_ready", iss_ready, 1);
        check_eq("e_lsu_ready", lsu_ready, 1);
        tick();
        iss_valid = 0; lsu_valid = 0; settle();
        check_eq("e_rs1_busy", rs1_busy, 0);
        check_eq("e_rf_wen", rf_wen, 0);
        tick();
        check_eq("e_rf_wen2", rf_wen, 0);
        check_eq("e_err", err, 0);

        // Both sources valid for four cycles: round-robin grants.
        iss_valid = 1; iss_rd = 1; tick();
        iss_rd = 2; tick();
        iss_valid = 0;
        for (int k = 0; k < 4; k++) begin
            exu_valid = 1; exu_rd = 1; exu_data = 32'h10000000 + k;
            lsu_valid = 1; lsu_rd = 2; lsu_data = 32'h20000000 + k;
            settle();
            grant_lsu    = !exp_last_lsu;
            exp_last_lsu = grant_lsu;
            check_eq("c_exu_ready", exu_ready, !grant_lsu);
            check_eq("c_lsu_ready", lsu_ready, grant_lsu);
            if (grant_lsu) push(2, lsu_data);
            else           push(1, exu_data);
            tick();
            check_eq("c_rf_wen", rf_wen, 1);
        end
        exu_valid = 0; lsu_valid = 0;
        tick(); tick();
        check_eq("c_err_nonbusy", err, 1);
        check_eq("c_drain", exp_q.size(), 0);

        // Asynchronous reset while a write is on the port and x5 is busy.
        rs1 = 5; iss_valid = 1; iss_rd = 5; tick();
        iss_valid = 0; exu_valid = 1; exu_rd = 7; exu_data = 32'h77; tick();
        exu_valid = 0; settle();
        check_eq("r_pre_rf_wen", rf_wen, 1);
        check_eq("r_pre_busy5", rs1_busy, 1);
        #1 rst = 1'b0;
        #1;
        check_eq("r_rf_wen", rf_wen, 0);
        check_eq("r_busy5", rs1_busy, 0);
        check_eq("r_err", err, 0);
        check_eq("r_rf_rd", rf_rd, 0);
        exp_q.delete();
        exp_last_lsu = 1'b0;
        tick();
        rst = 1'b1;
        tick();

        // After reset the first conflict goes to LSU.
        exu_valid = 1; exu_rd = 0; lsu_valid = 1; lsu_rd = 0; settle();
        check_eq("r_arb_lsu_ready", lsu_ready, 1);
        check_eq("r_arb_exu_ready", exu_ready, 0);
        tick();
        exu_valid = 0; lsu_valid = 0;
        tick();
        check_eq("r_err_after", err, 0);

        // Result to a non-busy register: written, err set and sticky.
        exu_valid = 1; exu_rd = 4; exu_data = 32'h44444444;
        push(4, 32'h44444444);
        tick();
        exu_valid = 0; settle();
        check_eq("f_x4_rf_wen", rf_wen, 1);
        check_eq("f_x4_rf_rd", rf_rd, 4);
        check_eq("f_x4_err", err, 1);
        tick(); tick();
        check_eq("f_x4_err_sticky", err, 1);

        rst = 1'b0; tick(); tick();
        check_eq("f_rst_err", err, 0);
        rst = 1'b1; tick();

        // Illegal issue index: err set, no busy bit touched.
        rs1 = 17; rs2 = 1; iss_valid = 1; iss_rd = 17; settle();
        check_eq("f_iss17_ready", iss_ready, 1);
        check_eq("f_rs1_17_busy", rs1_busy, 0);
        tick();
        iss_valid = 0; settle();
        check_eq("f_iss17_err", err, 1);
        check_eq("f_iss17_alias", rs2_busy, 0);
        lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h20; settle();
        check_eq("f_lsu20_ready", lsu_ready, 1);
        tick();
        lsu_valid = 0; settle();
        check_eq("f_lsu20_rf_wen", rf_wen, 0);
        tick(); tick();
        check_eq("f_err_sticky", err, 1);
        check_eq("final_drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
